// File: rtl/tlul_sram_responder.sv
// rtl/tlul_sram_responder.sv - TL-UL SRAM responder; optional poison tracking under TLUL_SRAM_POISON_EN
module tlul_sram_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int TL_RS       = 4,
    parameter int MAX_SIZE    = 6,
    parameter int AW          = $clog2(DEPTH_WORDS) + 2
) (
    input  logic             mem_clock_i,
    input  logic             mem_reset_i,
    input  logic [2:0]       mem_a_opcode,
    input  logic [2:0]       mem_a_param,
    input  logic [3:0]       mem_a_size,
    input  logic [TL_RS-1:0] mem_a_source,
    input  logic [AW-1:0]    mem_a_address,
    input  logic [3:0]       mem_a_mask,
    input  logic [31:0]      mem_a_data,
    input  logic             mem_a_corrupt,
    input  logic             mem_a_valid,
    output logic             mem_a_ready,
    output logic [2:0]       mem_d_opcode,
    output logic [2:0]       mem_d_param,
    output logic [3:0]       mem_d_size,
    output logic [TL_RS-1:0] mem_d_source,
    output logic             mem_d_denied,
    output logic [31:0]      mem_d_data,
    output logic             mem_d_corrupt,
    output logic             mem_d_valid,
    input  logic             mem_d_ready
);
    localparam int WW = AW - 2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WBURST = 2'd1;
    localparam logic [1:0] ST_RBURST = 2'd2;
    localparam logic [1:0] ST_WRESP  = 2'd3;

    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_GET         = 3'd4;

    localparam logic [3:0] MAX_SIZE_L = 4'(MAX_SIZE);

    // Word index of a beat; wraps naturally because the index width is exact.
    function automatic logic [WW-1:0] beat_word(input logic [WW-1:0] base, input logic [12:0] idx);
        return base + WW'(idx);
    endfunction

    logic [1:0]       state_q,     state_d;
    logic [12:0]      beat_cnt_q,  beat_cnt_d;
    logic [12:0]      beats_m1_q,  beats_m1_d;
    logic [2:0]       opcode_q,    opcode_d;
    logic [3:0]       size_q,      size_d;
    logic [TL_RS-1:0] source_q,    source_d;
    logic [WW-1:0]    base_word_q, base_word_d;
    logic             denied_q,    denied_d;

    logic             a_fire;
    logic [12:0]      req_beats_m1;
    logic [31:0]      align_mask;
    logic             misaligned;
    logic             bad_op;
    logic             req_denied;

    logic             wr_en;
    logic [WW-1:0]    wr_addr;
    logic [3:0]       wr_be;
    logic             rd_en;
    logic [WW-1:0]    rd_addr;
    logic [31:0]      rdata_q;
    logic             word_poison;
    logic             d_active;

    logic [31:0]      mem_array [DEPTH_WORDS];

    assign mem_a_ready = (state_q == ST_IDLE) || (state_q == ST_WBURST);
    assign a_fire      = mem_a_valid && mem_a_ready;

    // First-beat request decode: beat count and the three reasons to deny.
    assign req_beats_m1 = (mem_a_size <= 4'd2) ? 13'd0
                        : ((13'd1 << (mem_a_size - 4'd2)) - 13'd1);
    assign align_mask   = ~(32'hFFFF_FFFF << mem_a_size);
    assign misaligned   = |(32'(mem_a_address) & align_mask);
    assign bad_op       = !((mem_a_opcode == OP_PUT_FULL) || (mem_a_opcode == OP_PUT_PARTIAL) ||
                            (mem_a_opcode == OP_GET));
    assign req_denied   = (mem_a_size > MAX_SIZE_L) || misaligned || bad_op;

    // Transaction FSM: latches the first A beat and sequences write/read beats.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        beats_m1_d  = beats_m1_q;
        opcode_d    = opcode_q;
        size_d      = size_q;
        source_d    = source_q;
        base_word_d = base_word_q;
        denied_d    = denied_q;
        wr_en       = 1'b0;
        wr_addr     = beat_word(base_word_q, beat_cnt_q);
        wr_be       = (opcode_q == OP_PUT_FULL) ? 4'hF : mem_a_mask;
        rd_en       = 1'b0;
        rd_addr     = beat_word(base_word_q, beat_cnt_q);
        case (state_q)
            ST_IDLE: begin
                if (a_fire) begin
                    opcode_d    = mem_a_opcode;
                    size_d      = mem_a_size;
                    source_d    = mem_a_source;
                    base_word_d = mem_a_address[AW-1:2];
                    denied_d    = req_denied;
                    beats_m1_d  = req_beats_m1;
                    if (mem_a_opcode == OP_GET) begin
                        rd_en      = 1'b1;
                        rd_addr    = mem_a_address[AW-1:2];
                        beat_cnt_d = 13'd0;
                        state_d    = ST_RBURST;
                    end else begin
                        // Unknown opcodes travel the write path so every beat is drained.
                        wr_en   = !req_denied;
                        wr_addr = mem_a_address[AW-1:2];
                        wr_be   = (mem_a_opcode == OP_PUT_FULL) ? 4'hF : mem_a_mask;
                        if (req_beats_m1 == 13'd0) begin
                            beat_cnt_d = 13'd0;
                            state_d    = ST_WRESP;
                        end else begin
                            beat_cnt_d = 13'd1;
                            state_d    = ST_WBURST;
                        end
                    end
                end
            end
            ST_WBURST: begin
                if (a_fire) begin
                    wr_en = !denied_q;
                    if (beat_cnt_q == beats_m1_q) begin
                        beat_cnt_d = 13'd0;
                        state_d    = ST_WRESP;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 13'd1;
                    end
                end
            end
            ST_WRESP: begin
                if (mem_d_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RBURST: begin
                // The next word is fetched only on a handshake so stalled data stays put.
                if (mem_d_ready) begin
                    if (beat_cnt_q == beats_m1_q) begin
                        beat_cnt_d = 13'd0;
                        state_d    = ST_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 13'd1;
                        rd_en      = 1'b1;
                        rd_addr    = beat_word(base_word_q, beat_cnt_q + 13'd1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and latched-request registers.
    always_ff @(posedge mem_clock_i or posedge mem_reset_i) begin
        if (mem_reset_i) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= 13'd0;
            beats_m1_q  <= 13'd0;
            opcode_q    <= 3'd0;
            size_q      <= 4'd0;
            source_q    <= '0;
            base_word_q <= '0;
            denied_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            beats_m1_q  <= beats_m1_d;
            opcode_q    <= opcode_d;
            size_q      <= size_d;
            source_q    <= source_d;
            base_word_q <= base_word_d;
            denied_q    <= denied_d;
        end
    end

    // Word array with byte-lane writes and a registered read port; contents survive reset.
    always_ff @(posedge mem_clock_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_array[wr_addr][8*b +: 8] <= mem_a_data[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            rdata_q <= mem_array[rd_addr];
        end
    end

`ifdef TLUL_SRAM_POISON_EN
    logic [DEPTH_WORDS-1:0] poison_q;
    logic                   poison_rd_q;
    logic                   unused_inputs;

    // Per-word poison bits, tracked alongside the data and read with the same latency.
    always_ff @(posedge mem_clock_i or posedge mem_reset_i) begin
        if (mem_reset_i) begin
            poison_q    <= '0;
            poison_rd_q <= 1'b0;
        end else begin
            if (wr_en) begin
                poison_q[wr_addr] <= mem_a_corrupt;
            end
            if (rd_en) begin
                poison_rd_q <= poison_q[rd_addr];
            end
        end
    end

    assign word_poison   = poison_rd_q;
    assign unused_inputs = ^mem_a_param;
`else
    logic unused_inputs;

    assign word_poison   = 1'b0;
    assign unused_inputs = ^{mem_a_param, mem_a_corrupt};
`endif

    // D channel is driven purely from registered state, never from the A inputs.
    assign d_active      = (state_q == ST_WRESP) || (state_q == ST_RBURST);
    assign mem_d_valid   = d_active;
    assign mem_d_opcode  = (state_q == ST_RBURST) ? 3'd1 : 3'd0;
    assign mem_d_param   = 3'd0;
    assign mem_d_size    = d_active ? size_q : 4'd0;
    assign mem_d_source  = d_active ? source_q : '0;
    assign mem_d_denied  = d_active && denied_q;
    assign mem_d_data    = ((state_q == ST_RBURST) && !denied_q) ? rdata_q : 32'd0;
    assign mem_d_corrupt = (state_q == ST_RBURST) && (denied_q || word_poison);

endmodule

// File: doc/tlul_sram_responder.md
Name: tlul_sram_responder

Overview:
- TileLink-UL slave: SRAM that answers the DMA channel master ports (sa_*/sd_*) and any other TL-UL initiator on the fabric.
- Accepts Get, PutFullData and PutPartialData, including multi-beat bursts on a 32-bit bus.
- Returns AccessAckData or AccessAck on the D channel.
- Memory is an internal synchronous-read word array with per-byte write enables.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two.
- TL_RS, 4, source ID width.
- MAX_SIZE, 6, largest legal log2 transfer size in bytes; 6 = 64 B = 16 beats.
- AW, $clog2(DEPTH_WORDS)+2, byte address width (derived).

Ports:
- mem_clock_i  in  1  clock
- mem_reset_i  in  1  asynchronous active-high reset
- mem_a_opcode  in  3  0=PutFull, 1=PutPartial, 4=Get
- mem_a_param  in  3  ignored
- mem_a_size  in  4  log2 bytes
- mem_a_source  in  TL_RS  request ID
- mem_a_address  in  AW  byte address
- mem_a_mask  in  4  byte lanes
- mem_a_data  in  32  write data
- mem_a_corrupt  in  1  write poison
- mem_a_valid  in  1  A valid
- mem_a_ready  out  1  A ready
- mem_d_opcode  out  3  0=AccessAck, 1=AccessAckData
- mem_d_param  out  3  always 0
- mem_d_size  out  4  echo of request size
- mem_d_source  out  TL_RS  echo of request source
- mem_d_denied  out  1  request rejected
- mem_d_data  out  32  read data
- mem_d_corrupt  out  1  data invalid
- mem_d_valid  out  1  D valid
- mem_d_ready  in  1  D ready

Behaviour:
- Reset: all D outputs 0; mem_a_ready=1; state IDLE; beat counter 0. Memory contents are not reset.
- FSM states: IDLE, WBURST, RBURST, WRESP.
- Beats per transfer = 1 if size<=2, else 2^(size-2). Beat counter is 13 bits, so it covers size up to 15.
- First-beat latch: opcode, size, source, base address and the denied flag are latched on the first A beat. Later beats' opcode, size and address are ignored.
- Denied when any of:
  - size > MAX_SIZE;
  - address not aligned to 2^size;
  - opcode not in {0,1,4}.
- Beat address = base word address + beat index. Word index wraps modulo DEPTH_WORDS; it is never out of range because AW is exact.
- IDLE, Put accepted:
  - Writes the beat when not denied. Byte enables = mem_a_mask, or all 1s for PutFull.
  - Single beat -> WRESP; otherwise -> WBURST.
- WBURST:
  - mem_a_ready=1.
  - Each accepted beat writes the next word.
  - Last beat -> WRESP.
- WRESP:
  - mem_a_ready=0.
  - D: opcode=0, data=0, denied=latched flag, corrupt=0.
  - mem_d_valid is asserted the cycle after the last A beat is accepted.
  - On d_ready -> IDLE.
- Denied Put: all beats are consumed, memory is untouched, and the ack carries denied=1.
- IDLE, Get accepted:
  - mem_a_ready drops next cycle; -> RBURST.
  - First D beat is valid 1 cycle after acceptance (registered SRAM read).
- RBURST:
  - D opcode=1.
  - Beats stream back-to-back while mem_d_ready=1.
  - On a stall, d_data, d_valid and all D fields hold stable. The next-word read is issued only on the d_valid & d_ready handshake.
  - After the last beat handshakes -> IDLE, with mem_a_ready=1 that same cycle.
- Denied Get: the full beat count is returned, each beat with data=0, denied=1, corrupt=1.
- Sub-word Get (size 0/1) returns the full aligned word; the master selects lanes.
- One transaction in flight at a time; no A acceptance outside IDLE/WBURST.
- mem_d_valid never depends combinationally on mem_a_valid.
- Reset asserted mid-burst: immediate return to IDLE and outputs to reset values. A partially written burst stays partially written.

Optional Feature:
- Macro: TLUL_SRAM_POISON_EN.
- Enabled:
  - Adds a DEPTH_WORDS x 1 poison array, cleared at reset.
  - A non-denied Put beat sets the word's poison bit to mem_a_corrupt.
  - Get beats report mem_d_corrupt = poison bit of the word read. mem_d_denied is unaffected.
- Disabled:
  - mem_a_corrupt is ignored.
  - mem_d_corrupt=1 only on denied Get beats.

Test Plan:
- PutFull, size 2, addr 0x10, data 0xDEADBEEF; then Get, size 2, addr 0x10 -> AccessAck (denied=0); then AccessAckData with data 0xDEADBEEF, source echoed, d_valid exactly 1 cycle after A accept.
- PutPartial, mask 4'b0101, data 0x11223344 over a word holding 0xFFFFFFFF, then Get -> 0xFF22FF44.
- 16-beat PutFull (size 6, addr 0x40, data = beat index), then a 16-beat Get with d_ready toggling every cycle -> exactly 16 beats; data 0..15 in order; data held stable on stalled cycles; one AccessAck for the Put.
- Get, size 6, addr 0x44 (misaligned) -> 16 beats, each with denied=1, corrupt=1, data 0. Get, size 7 -> denied. Put, opcode 2 -> consumed, ack with denied=1, memory unchanged.
- Reset asserted on beat 5 of a 16-beat Get -> d_valid=0 and a_ready=1 next cycle; a following Get returns correct data.
- TLUL_SRAM_POISON_EN: Put addr 0x8 with a_corrupt=1, then Get -> d_corrupt=1, denied=0. Rewrite the same word with a_corrupt=0, then Get -> d_corrupt=0.
